// File: rtl/rv32_multicycle_ctrl.sv
// rtl/rv32_multicycle_ctrl.sv - multi-cycle RV32I control FSM
module rv32_multicycle_ctrl #(
    parameter bit RESET_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [15:0] alu_op,
    output logic [2:0]  imm_type,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    input  logic        cmp_eq,
    input  logic        cmp_lt,
    input  logic        cmp_ltu,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic        halted
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {C_ALU, C_JUMP, C_BRANCH, C_LOAD, C_STORE, C_FENCE, C_SYS, C_BAD} class_t;

    localparam logic [15:0] OP_ADD = 16'd0, OP_SUB = 16'd1, OP_AND = 16'd2, OP_OR = 16'd3;
    localparam logic [15:0] OP_XOR = 16'd4, OP_SLL = 16'd5, OP_SRL = 16'd6, OP_SRA = 16'd7;
    localparam logic [15:0] OP_SLT = 16'd8, OP_SLTU = 16'd9, OP_BPASS = 16'd11, OP_NOP = 16'h00FF;
    localparam logic [2:0]  IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;
    localparam logic [1:0]  A_RS1 = 2'd0, A_PC = 2'd1;
    localparam logic        B_RS2 = 1'b0, B_IMM = 1'b1;
    localparam logic [1:0]  WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
    localparam logic [1:0]  PC_SEQ = 2'd0, PC_ALU = 2'd1, PC_ALIGN = 2'd2;

    state_t      state, state_nx;
    class_t      cls_q, cls_d;
    logic        run;
    logic [31:0] ir;
    logic [15:0] op_q, op_d, base_op;
    logic [2:0]  imm_q, imm_d;
    logic [1:0]  a_q, a_d, wb_q, wb_d, jsel_q, jsel_d;
    logic        b_q, b_d, illegal_q, taken;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;

    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];
    assign rd  = ir[11:7];

    assign instr     = ir;
    assign alu_a_sel = a_q;
    assign alu_b_sel = b_q;
    assign wb_sel    = wb_q;
    assign illegal   = illegal_q;
    assign halted    = (state == S_HALT);

    // funct3 to base ALU operation shared by OP and OP-IMM
    always_comb begin
        case (f3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    end

    // instruction decode from the latched IR
    always_comb begin
        cls_d  = C_BAD;
        op_d   = OP_ADD;
        imm_d  = IMM_NONE;
        a_d    = A_RS1;
        b_d    = B_IMM;
        wb_d   = WB_ALU;
        jsel_d = PC_SEQ;
        case (opc)
            7'b0110111: begin cls_d = C_ALU; op_d = OP_BPASS; imm_d = IMM_U; end
            7'b0010111: begin cls_d = C_ALU; a_d = A_PC; imm_d = IMM_U; end
            7'b1101111: begin
                cls_d = C_JUMP; a_d = A_PC; imm_d = IMM_J; jsel_d = PC_ALU; wb_d = WB_PC4;
            end
            7'b1100111: begin
                if (f3 == 3'b000) cls_d = C_JUMP;
                imm_d = IMM_I; jsel_d = PC_ALIGN; wb_d = WB_PC4;
            end
            7'b1100011: begin
                if (f3[2:1] != 2'b01) cls_d = C_BRANCH;
                a_d = A_PC; imm_d = IMM_B;
            end
            7'b0000011: begin cls_d = C_LOAD; imm_d = IMM_I; wb_d = WB_MEM; end
            7'b0100011: begin cls_d = C_STORE; imm_d = IMM_S; end
            7'b0010011: begin
                imm_d = IMM_I;
                op_d  = base_op;
                if (f3 == 3'b001) begin
                    if (f7 == 7'b0000000) cls_d = C_ALU;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0000000) cls_d = C_ALU;
                    else if (f7 == 7'b0100000) begin cls_d = C_ALU; op_d = OP_SRA; end
                end else begin
                    cls_d = C_ALU;
                end
            end
            7'b0110011: begin
                b_d  = B_RS2;
                op_d = base_op;
                if (f7 == 7'b0000000) cls_d = C_ALU;
                else if (f7 == 7'b0100000 && f3 == 3'b000) begin cls_d = C_ALU; op_d = OP_SUB; end
                else if (f7 == 7'b0100000 && f3 == 3'b101) begin cls_d = C_ALU; op_d = OP_SRA; end
            end
            7'b0001111: begin cls_d = C_FENCE; op_d = OP_NOP; end
            7'b1110011: begin
                if (ir == 32'h0000_0073 || ir == 32'h0010_0073) cls_d = C_SYS;
            end
            default: cls_d = C_BAD;
        endcase
    end

    // branch condition from the comparator flags
    always_comb begin
        case (f3)
            3'b000:  taken = cmp_eq;
            3'b001:  taken = !cmp_eq;
            3'b100:  taken = cmp_lt;
            3'b101:  taken = !cmp_lt;
            3'b110:  taken = cmp_ltu;
            3'b111:  taken = !cmp_ltu;
            default: taken = 1'b0;
        endcase
    end

    // state register; run holds off fetch requests until the first clock after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_HALT ? S_HALT : S_FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    // IR capture, decoded controls held from DECODE to the end of the instruction, sticky illegal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= 32'd0;
            cls_q     <= C_ALU;
            op_q      <= OP_NOP;
            imm_q     <= IMM_NONE;
            a_q       <= A_RS1;
            b_q       <= B_RS2;
            wb_q      <= WB_ALU;
            jsel_q    <= PC_SEQ;
            illegal_q <= 1'b0;
        end else begin
            if (state == S_FETCH && run && imem_ack) ir <= imem_rdata;
            if (state == S_DECODE) begin
                cls_q  <= cls_d;
                op_q   <= op_d;
                imm_q  <= imm_d;
                a_q    <= a_d;
                b_q    <= b_d;
                wb_q   <= wb_d;
                jsel_q <= jsel_d;
                if (cls_d == C_BAD) illegal_q <= 1'b1;
            end
        end
    end

    // next state and per-state strobes
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEQ;
        alu_op   = op_q;
        imm_type = imm_q;
        case (state)
            S_FETCH: begin
                alu_op   = OP_NOP;
                imm_type = IMM_NONE;
                imem_req = run;
                if (run && imem_ack) state_nx = S_DECODE;
            end
            S_DECODE: begin
                alu_op   = OP_NOP;
                imm_type = IMM_NONE;
                state_nx = (cls_d == C_SYS || cls_d == C_BAD) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_BRANCH: begin
                        pc_we    = 1'b1;
                        pc_sel   = taken ? PC_ALU : PC_SEQ;
                        state_nx = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_nx = S_MEM;
                    C_FENCE: begin
                        pc_we    = 1'b1;
                        state_nx = S_FETCH;
                    end
                    default: state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
                if (dmem_ack) begin
                    if (cls_q == C_STORE) begin
                        pc_we    = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = (rd != 5'd0);
                pc_we    = 1'b1;
                pc_sel   = jsel_q;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                alu_op   = OP_NOP;
                imm_type = IMM_NONE;
            end
            default: state_nx = S_FETCH;
        endcase
    end
endmodule

// File: doc/rv32_multicycle_ctrl.md
Name: rv32_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Fetches each instruction over an imem req/ack handshake, decodes it, and sequences the shared ALU, data memory, register-file write and PC update.
- Drives alu_op and imm_type using the core's standard ALU-op and immediate-type encodings.
- One instruction in flight; no pipelining.

Parameters:
- RESET_HALT, 0, if 1 the FSM enters HALT after reset and ignores imem until the next reset (bring-up aid).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction
- instr  out  32  latched instruction register (IR)
- alu_op  out  16  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, A_PASS=10, B_PASS=11, NOP=16'h00FF
- imm_type  out  3  NONE=0, I=1, S=2, B=3, U=4, J=5
- alu_a_sel  out  2  0 rs1, 1 pc, 2 zero
- alu_b_sel  out  1  0 rs2, 1 imm
- cmp_eq  in  1  rs1==rs2
- cmp_lt  in  1  signed rs1<rs2
- cmp_ltu  in  1  unsigned rs1<rs2
- dmem_req  out  1  data access request
- dmem_we  out  1  store when 1
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe
- wb_sel  out  2  0 alu, 1 mem, 2 pc+4
- pc_we  out  1  PC update strobe
- pc_sel  out  2  0 pc+4, 1 alu result, 2 alu result & ~1
- illegal  out  1  sticky illegal-instruction flag
- halted  out  1  FSM in HALT

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async, asserted): state=FETCH (or HALT if RESET_HALT); all strobes 0; alu_op=16'h00FF; imm_type=0; instr=0; illegal=0; halted=0.
- Reset asserted mid-operation: request strobes drop immediately; no ack is honoured afterwards.
- FETCH: imem_req=1 held until imem_ack. On the ack cycle: IR<=imem_rdata, go to DECODE. imem_ack seen without imem_req is ignored.
- DECODE (1 cycle): register alu_op, imm_type, alu_a_sel, alu_b_sel, wb_sel and the class; hold them through EXEC, MEM and WB. In FETCH/DECODE/HALT, alu_op=00FF and imm_type=0.
- Decode by opcode (funct3 = IR[14:12], funct7 = IR[31:25], rd = IR[11:7]):
  - LUI 0110111: B_PASS, U, wb alu.
  - AUIPC 0010111: ADD, a=pc, U.
  - JAL 1101111: ADD, a=pc, J, pc_sel 1, wb pc+4.
  - JALR 1100111 with funct3=000: ADD, a=rs1, I, pc_sel 2, wb pc+4.
  - BRANCH 1100011: ADD, a=pc, B. funct3 010/011 are illegal.
  - LOAD 0000011: ADD, I, wb mem.
  - STORE 0100011: ADD, S.
  - OP-IMM 0010011: b=imm, I. funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND. 001 SLL requires funct7=0000000. 101 is SRL when funct7=0000000, SRA when 0100000.
  - OP 0110011: b=rs2. funct7 0000000 gives the base ops. funct7 0100000 is valid only with 000 (SUB) and 101 (SRA).
  - FENCE 0001111: NOP, pc+4 only.
  - IR=0x00000073 (ECALL) or 0x00100073 (EBREAK): HALT.
  - Anything else: illegal=1, go to HALT.
- EXEC (1 cycle):
  - BRANCH: pc_we=1. Taken per funct3 (000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu) gives pc_sel=1, else pc_sel=0. Go to FETCH.
  - LOAD/STORE: go to MEM.
  - FENCE: pc_we=1, pc_sel=0, go to FETCH.
  - All others: go to WB.
- MEM: dmem_req=1 (dmem_we=1 for stores) held until dmem_ack.
  - Store: on ack, pc_we=1, pc_sel=0, go to FETCH.
  - Load: on ack, go to WB.
- WB (1 cycle): rf_we=1 unless rd==0; pc_we=1 with the decoded pc_sel (0 for non-jumps); go to FETCH.
- HALT: absorbing until reset; halted=1; no requests issued.
- Latency with zero-wait acks:
  - ALU / LUI / AUIPC / JAL / JALR: 4 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- Strobes rf_we and pc_we are single-cycle pulses, at most one pc_we per instruction.

Test Plan:
- IR=0x002081B3 (add x3,x1,x2), zero-wait acks -> alu_op=0, b_sel=0, rf_we and pc_we pulse together in cycle 4, pc_sel=0, then imem_req again.
- IR=0x40208133 (sub) then 0x4020D113 (srai x2,x1,2) -> alu_op=1, then 7 with imm_type=1; IR=0x4020C133 -> illegal=1, halted=1.
- BEQ 0x00208463 with cmp_eq=1 then 0 -> pc_we in EXEC with pc_sel=1 then 0; rf_we never asserted.
- LW 0x0000A183 with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; wb_sel=1; rf_we one cycle after ack.
- JALR 0x000080E7 -> alu_op=0, imm_type=1, pc_sel=2, wb_sel=2, rf_we=1; same with rd=0 gives rf_we=0.
- rst_n low during MEM with dmem_req high -> dmem_req=0 asynchronously, alu_op=00FF; after release, imem_req=1 on the first clock.
